drf_bus_arbiter: RTL and testbench
==================================

# drf_bus_arbiter

Sequencing arbiter for the shared 8-bit `BUS` in `drf_system`. It collects drive requests from the bus drivers: control unit, register bank, data memory manager, ALU and PC. It issues a registered one-hot grant so exactly one driver owns `BUS` per cycle. The control unit has fixed top priority, and the remaining drivers share the bus round-robin. Multi-cycle ownership is supported through a lock, bounded by a watchdog.

## Interface
- `N_REQ`, default 5: number of requesters; index 0 is the control unit (priority), 1..N_REQ-1 are round-robin.
- `TIMEOUT`, default 15: maximum cycles a locked grant may be held before forced release; legal range 1..255.
- `clk  input  1`: system clock; all state updates on the rising edge.
- `rst  input  1`: reset, synchronous, active-high.
- `in_req  input  N_REQ`: per-requester bus request, level-sensitive.
- `in_lock  input  N_REQ`: per-requester lock; only the bit of the current grantee is observed.
- `out_grant  output  N_REQ`: registered one-hot grant; all-zero when the bus is idle.
- `out_grant_valid  output  1`: OR of `out_grant`.
- `out_grant_id  output  clog2(N_REQ)`: index of the grantee; 0 when idle.
- `out_timeout  output  1`: one-cycle pulse on watchdog release.
- `out_busy  output  1`: high in the LOCKED state.

## Operation
- FSM states: IDLE, GRANT, LOCKED.
- IDLE:
  - Any eligible request moves the FSM to GRANT with a winner.
  - With no eligible request, the FSM stays in IDLE and the grant is 0.
- Winner selection, evaluated combinationally on `in_req & ~penalty`:
  - Bit 0 wins if set.
  - Otherwise the winner is the first set bit among 1..N_REQ-1, searching upward from `rr_ptr` with wrap from N_REQ-1 to 1.
- GRANT lasts one cycle. At its end:
  - If the grantee's `in_lock` is high, go to LOCKED, keep the grant and clear `wd_cnt`.
  - Else, if another eligible request exists, go directly to GRANT with the new winner (back-to-back, no idle cycle).
  - Else, go to IDLE.
- LOCKED holds the grant unchanged while the grantee's `in_lock` is high; bit 0 does not preempt.
  - When `in_lock` drops: same exit as GRANT (re-arbitrate or go to IDLE).
  - When `wd_cnt == TIMEOUT-1` and lock is still high:
    - Release the grant and pulse `out_timeout`.
    - Set the grantee's `penalty` bit.
    - Re-arbitrate among the others.
- `rr_ptr` updates to (winner+1), wrapped within 1..N_REQ-1, whenever a winner ≥1 is granted. Bit-0 grants leave `rr_ptr` unchanged.
- A `penalty` bit clears in the cycle after its `in_req` is sampled low. A penalised requester is ineligible until then.
- If a grantee drops `in_req` during its grant, the registered grant still completes its cycle; lock semantics are unaffected.
- `in_lock` without a matching grant is ignored.

## Timing
- Request sampled at edge t produces a grant visible after edge t (one-cycle latency from IDLE).
- A grant is never shorter than one full cycle; `out_grant` is strictly one-hot or zero, and glitch-free because it is registered.
- A locked hold of k cycles (lock high in k consecutive grant cycles) gives a grant of k+1 cycles when k < TIMEOUT.
- Watchdog release: the grant is held for exactly TIMEOUT+1 cycles in total. `out_timeout` is high in the first cycle after release.
- Reset values:
  - Outputs: `out_grant=0`, `out_grant_valid=0`, `out_grant_id=0`, `out_timeout=0`, `out_busy=0`.
  - Internal: state IDLE, `rr_ptr=1`, `wd_cnt=0`, `penalty=0`.
- Reset asserted mid-lock: the grant is 0 from the edge where `rst` is sampled high, and no timeout pulse is produced.
- With simultaneous lock release and timeout in the same cycle, release wins: no pulse and no penalty.

## Structure
- Shared package `drf_pkg` holds:
  - Requester index constants: `REQ_CU=0`, `REQ_REG=1`, `REQ_MEM=2`, `REQ_ALU=3`, `REQ_PC=4`.
  - The arbiter state enum.
- Sub-module `drf_rr_picker`: combinational round-robin find-first over a request vector from a pointer. It returns a one-hot winner plus a found flag.
- `wd_cnt` width is 8 bits.

## Test plan
- Single request: `in_req=00100` at edge 0 → `out_grant=00100`, `id=2` for exactly one cycle after edge 0; then idle.
- Priority: `in_req=11111` held → the CU (bit 0) is granted every cycle and the others starve. Dropping bit 0 then gives the order 1,2,3,4,1 on consecutive cycles.
- Round-robin fairness: `in_req=11110` held for 8 cycles → grant ids 1,2,3,4,1,2,3,4, with `rr_ptr` wrapping from 4 to 1.
- Lock:
  - Requester 3 granted with `in_lock[3]` high for 4 grant cycles → grant of 5 cycles and `out_busy` high for 4.
  - Bit 0 requesting during the lock is granted the cycle after release.
- Watchdog with TIMEOUT=15: requester 2 locks indefinitely →
  - Grant held 16 cycles, then `out_timeout` pulses once.
  - Requester 4 is granted next.
  - Requester 2 is not regranted until its `in_req` is low for a cycle.
- Reset mid-lock: `rst` high during a LOCKED grant → all outputs 0 after that edge. After release, `in_req=01000` is granted with `rr_ptr` back at 1 behaviour (id 3).

Source files
------------

// File: rtl/drf_pkg.sv
// Shared definitions for the drf_system bus: requester indices and arbiter FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package drf_pkg;

    // Bus driver indices into the arbiter request/grant vectors.
    localparam int REQ_CU  = 0;
    localparam int REQ_REG = 1;
    localparam int REQ_MEM = 2;
    localparam int REQ_ALU = 3;
    localparam int REQ_PC  = 4;

    localparam int WD_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } arb_state_t;

endpackage

// File: rtl/drf_rr_picker.sv
// Round-robin find-first over req[N-1:1], starting at ptr and wrapping from N-1 back to 1.
// Latency: combinational.
// Backpressure: none; bit 0 is never selected here (it has fixed priority in the arbiter).
module drf_rr_picker #(
    parameter int N  = 5,
    parameter int PW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic          found
);

    // Two passes: ptr..N-1 first, then 1..ptr-1, so the first hit is the round-robin winner.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 1; i < N; i++) begin
            if (!found && (i >= int'(ptr)) && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int i = 1; i < N; i++) begin
            if (!found && (i < int'(ptr)) && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/drf_bus_arbiter.sv
// Shared BUS arbiter: CU (bit 0) fixed priority, others round-robin, lock with watchdog release.
// Latency: one cycle from request to registered one-hot grant; back-to-back grants with no idle gap.
// Backpressure: a locked grantee holds the bus until it drops lock or the watchdog forces release.
module drf_bus_arbiter
    import drf_pkg::*;
#(
    parameter int N_REQ   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         in_req,
    input  logic [N_REQ-1:0]         in_lock,
    output logic [N_REQ-1:0]         out_grant,
    output logic                     out_grant_valid,
    output logic [$clog2(N_REQ)-1:0] out_grant_id,
    output logic                     out_timeout,
    output logic                     out_busy
);

    localparam int            PW        = $clog2(N_REQ);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_FIRST = PW'(1);

    arb_state_t       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] penalty_q, penalty_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d, rr_next;
    logic [PW-1:0]    id_q, id_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             tmo_q, tmo_d;

    logic [N_REQ-1:0] excl;
    logic [N_REQ-1:0] elig;
    logic [N_REQ-1:0] rr_pick;
    logic [N_REQ-1:0] win;
    logic             rr_found;
    logic             any_elig;
    logic             lock_cur;
    logic             wd_expire;
    logic             rearb;

    // Only the current grantee's lock bit matters; stray locks are masked off.
    assign lock_cur  = |(in_lock & grant_q);
    // Watchdog fires only while lock is still held; a release in the same cycle takes precedence.
    assign wd_expire = (state_q == ST_LOCKED) && lock_cur && (wd_q == WD_LAST);
    // The grantee being forced off is excluded from the immediate re-arbitration.
    assign excl      = wd_expire ? grant_q : '0;
    assign elig      = in_req & ~penalty_q & ~excl;

    drf_rr_picker #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_picker (
        .req   (elig),
        .ptr   (rr_ptr_q),
        .grant (rr_pick),
        .found (rr_found)
    );

    // Winner: CU beats everything, otherwise the round-robin pick.
    always_comb begin
        win      = rr_pick;
        any_elig = elig[REQ_CU] | rr_found;
        if (elig[REQ_CU]) begin
            win         = '0;
            win[REQ_CU] = 1'b1;
        end
    end

    // Pointer moves just past the round-robin winner, wrapping within 1..N_REQ-1.
    always_comb begin
        rr_next = rr_ptr_q;
        for (int i = 1; i < N_REQ; i++) begin
            if (rr_pick[i]) begin
                rr_next = (i == N_REQ - 1) ? PTR_FIRST : PW'(i + 1);
            end
        end
    end

    // FSM next-state and grant/watchdog/pointer updates.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        wd_d     = wd_q;
        tmo_d    = 1'b0;
        rr_ptr_d = rr_ptr_q;
        rearb    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rearb = 1'b1;
            end
            ST_GRANT: begin
                if (lock_cur) begin
                    state_d = ST_LOCKED;
                    wd_d    = '0;
                end else begin
                    rearb = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (!lock_cur) begin
                    rearb = 1'b1;
                end else if (wd_expire) begin
                    rearb = 1'b1;
                    tmo_d = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (rearb) begin
            if (any_elig) begin
                state_d = ST_GRANT;
                grant_d = win;
                if (!elig[REQ_CU]) begin
                    rr_ptr_d = rr_next;
                end
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        end
    end

    // Penalty persists while the requester keeps asking; a forced release sets it.
    always_comb begin
        penalty_d = (penalty_q & in_req) | excl;
    end

    // Encode the next grant so the id is registered alongside the one-hot vector.
    always_comb begin
        id_d = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_d[i]) begin
                id_d = PW'(i);
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            penalty_q <= '0;
            rr_ptr_q  <= PTR_FIRST;
            wd_q      <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            id_q      <= id_d;
            penalty_q <= penalty_d;
            rr_ptr_q  <= rr_ptr_d;
            wd_q      <= wd_d;
            tmo_q     <= tmo_d;
        end
    end

    assign out_grant       = grant_q;
    assign out_grant_valid = |grant_q;
    assign out_grant_id    = id_q;
    assign out_timeout     = tmo_q;
    assign out_busy        = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_drf_bus_arbiter.sv
module tb_drf_bus_arbiter;
    import drf_pkg::*;

    localparam int N = 5;

    logic         clk;
    logic         rst;
    logic [N-1:0] in_req;
    logic [N-1:0] in_lock;
    logic [N-1:0] out_grant;
    logic         out_grant_valid;
    logic [2:0]   out_grant_id;
    logic         out_timeout;
    logic         out_busy;

    int checks;
    int passed;

    typedef struct {
        string        tag;
        logic [N-1:0] grant;
        logic         tmo;
        logic         busy;
    } exp_t;

    exp_t sb[$];

    drf_bus_arbiter #(
        .N_REQ   (N),
        .TIMEOUT (15)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_req          (in_req),
        .in_lock         (in_lock),
        .out_grant       (out_grant),
        .out_grant_valid (out_grant_valid),
        .out_grant_id    (out_grant_id),
        .out_timeout     (out_timeout),
        .out_busy        (out_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pop_check();
        exp_t        e;
        logic [2:0]  eid;
        if (sb.size() == 0) begin
            check("scoreboard_underflow", 32'd1, 32'd0);
            return;
        end
        e   = sb.pop_front();
        eid = '0;
        for (int i = 0; i < N; i++) if (e.grant[i]) eid = 3'(i);
        check({e.tag, ".grant"},   32'(out_grant),       32'(e.grant));
        check({e.tag, ".valid"},   32'(out_grant_valid), 32'(|e.grant));
        check({e.tag, ".id"},      32'(out_grant_id),    32'(eid));
        check({e.tag, ".timeout"}, 32'(out_timeout),     32'(e.tmo));
        check({e.tag, ".busy"},    32'(out_busy),        32'(e.busy));
    endtask

    // Drive one cycle of stimulus, queue what must appear after the edge, then compare.
    task automatic cyc(input logic r, input logic [N-1:0] req, input logic [N-1:0] lock,
                       input logic [N-1:0] eg, input logic et, input logic eb, input string tag);
        exp_t e;
        rst     = r;
        in_req  = req;
        in_lock = lock;
        e.tag   = tag;
        e.grant = eg;
        e.tmo   = et;
        e.busy  = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_check();
    endtask

    initial begin
        logic [N-1:0] g_reg, g_mem, g_alu, g_pc, g_cu;
        checks  = 0;
        passed  = 0;
        rst     = 1'b1;
        in_req  = '0;
        in_lock = '0;
        g_cu  = '0; g_cu[REQ_CU]   = 1'b1;
        g_reg = '0; g_reg[REQ_REG] = 1'b1;
        g_mem = '0; g_mem[REQ_MEM] = 1'b1;
        g_alu = '0; g_alu[REQ_ALU] = 1'b1;
        g_pc  = '0; g_pc[REQ_PC]   = 1'b1;

        // Reset state
        cyc(1, 5'b00000, 5'b00000, 5'b00000, 0, 0, "reset0");
        cyc(1, 5'b00000, 5'b00000, 5'b00000, 0, 0, "reset1");

        // Priority: CU wins every cycle, others starve
        for (int i = 0; i < 3; i++) cyc(0, 5'b11111, 5'b00000, g_cu, 0, 0, "prio_cu");
        // Drop CU: 1,2,3,4,1 back to back
        cyc(0, 5'b11110, 5'b00000, g_reg, 0, 0, "prio_rr1");
        cyc(0, 5'b11110, 5'b00000, g_mem, 0, 0, "prio_rr2");
        cyc(0, 5'b11110, 5'b00000, g_alu, 0, 0, "prio_rr3");
        cyc(0, 5'b11110, 5'b00000, g_pc,  0, 0, "prio_rr4");
        cyc(0, 5'b11110, 5'b00000, g_reg, 0, 0, "prio_rr5");
        cyc(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, "prio_idle");

        // Single request: one grant cycle then idle
        cyc(0, 5'b00100, 5'b00000, g_mem,    0, 0, "single");
        cyc(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, "single_end");
        cyc(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, "single_idle");

        // Round-robin fairness from a fresh pointer
        cyc(1, 5'b00000, 5'b00000, 5'b00000, 0, 0, "rr_reset");
        for (int k = 0; k < 2; k++) begin
            cyc(0, 5'b11110, 5'b00000, g_reg, 0, 0, "rr_1");
            cyc(0, 5'b11110, 5'b00000, g_mem, 0, 0, "rr_2");
            cyc(0, 5'b11110, 5'b00000, g_alu, 0, 0, "rr_3");
            cyc(0, 5'b11110, 5'b00000, g_pc,  0, 0, "rr_4");
        end
        cyc(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, "rr_idle");

        // Lock: ALU holds 4 grant cycles, CU waits and gets the bus right after release
        cyc(0, 5'b01000, 5'b00000, g_alu, 0, 0, "lock_grant");
        for (int i = 0; i < 4; i++) cyc(0, 5'b01001, 5'b01000, g_alu, 0, 1, "lock_hold");
        cyc(0, 5'b00001, 5'b00000, g_cu,     0, 0, "lock_cu_after");
        cyc(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, "lock_idle");

        // Watchdog: MEM locks forever, PC waiting
        cyc(0, 5'b00100, 5'b00000, g_mem, 0, 0, "wd_grant");
        for (int i = 0; i < 15; i++) cyc(0, 5'b10100, 5'b00100, g_mem, 0, 1, "wd_hold");
        cyc(0, 5'b10100, 5'b00100, g_pc,  1, 0, "wd_release");
        cyc(0, 5'b10100, 5'b00000, g_pc,  0, 0, "wd_penalised1");
        cyc(0, 5'b10100, 5'b00000, g_pc,  0, 0, "wd_penalised2");
        cyc(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, "wd_req_low");
        cyc(0, 5'b00100, 5'b00000, g_mem, 0, 0, "wd_regrant");

        // Reset mid-lock: no grant, no timeout pulse; pointer back at 1
        cyc(0, 5'b00100, 5'b00100, g_mem,    0, 1, "rst_lock");
        cyc(1, 5'b00100, 5'b00100, 5'b00000, 0, 0, "rst_mid");
        cyc(0, 5'b01000, 5'b00000, g_alu,    0, 0, "rst_after");
        cyc(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, "rst_idle");

        // Lock dropped exactly when watchdog would fire: release wins, no penalty
        cyc(0, 5'b00100, 5'b00000, g_mem, 0, 0, "race_grant");
        for (int i = 0; i < 15; i++) cyc(0, 5'b00100, 5'b00100, g_mem, 0, 1, "race_hold");
        cyc(0, 5'b00100, 5'b00000, g_mem,    0, 0, "race_release");
        cyc(0, 5'b00000, 5'b00000, 5'b00000, 0, 0, "race_idle");

        // Stray lock without a grant is ignored
        cyc(0, 5'b00000, 5'b11111, 5'b00000, 0, 0, "stray_lock");

        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
